// File: rtl/fixed_to_float_pkg.sv
// Shared types and IEEE-754 single-precision field constants for fixed_to_float.
package fixed_to_float_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned EXP_W    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StNormalise,
        StRound,
        StPack,
        StPutZ
    } state_t;

    typedef struct packed {
        logic                sign;
        logic [EXP_W-1:0]    exp;
        logic [MANT_W-1:0]   mant;
    } float32_t;

endpackage

// File: rtl/fixed_to_float_lzc.sv
// Leading-zero counter: number of zero bits above the highest set bit of i_vec.
// An all-zero input reports WIDTH.
module fixed_to_float_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]           i_vec,
    output logic [$clog2(WIDTH+1)-1:0] o_cnt
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Scan upward so the highest set bit is the last one to update the count.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fixed_to_float.sv
// Fixed-point to IEEE-754 single-precision converter with strobe/ack handshakes.
// Round-to-nearest-even; one conversion in flight.
// Build option: define FIXED_TO_FLOAT_LZC_EN for a single-cycle normalise stage
// (leading-zero count + barrel shift); otherwise normalise shifts one bit per cycle.
module fixed_to_float
    import fixed_to_float_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] input_a,
    input  logic            input_a_stb,
    output logic            input_a_ack,
    output logic [31:0]     output_z,
    output logic            output_z_stb,
    input  logic            output_z_ack
);

    // Extended vector: magnitude followed by room for a 24-bit mantissa, guard and round.
    localparam int unsigned PAD_W = MANT_W + 3;
    localparam int unsigned EXT_W = IN_W + PAD_W;

    localparam logic signed [9:0] EXP_INIT   = 10'(IN_W - 1 - FRAC_W);
    localparam logic signed [9:0] EXP_BIAS_S = 10'(EXP_BIAS);
    localparam logic signed [9:0] EXP_ZERO   = -EXP_BIAS_S;

    state_t             r_state, w_state_n;

    logic [IN_W-1:0]    r_a, w_a_n;
    logic               r_sign, w_sign_n;
    logic [IN_W-1:0]    r_mag, w_mag_n;
    logic signed [9:0]  r_exp, w_exp_n;
    logic [MANT_W:0]    r_mant, w_mant_n;
    logic               r_guard, w_guard_n;
    logic               r_round, w_round_n;
    logic               r_sticky, w_sticky_n;
    float32_t           r_z, w_z_n;
    logic               r_ack, w_ack_n;
    logic               r_stb, w_stb_n;

    logic               w_zero;
    logic               w_in_sign;
    logic [IN_W-1:0]    w_abs;
    logic [IN_W-1:0]    w_norm;
    logic signed [9:0]  w_norm_exp;
    logic               w_norm_done;
    logic [EXT_W-1:0]   w_ext;
    logic [MANT_W:0]    w_mant_ext;
    logic               w_guard_ext;
    logic               w_round_ext;
    logic               w_sticky_ext;
    logic               w_inc;

    // Operand decode; the most negative value maps to magnitude 2^(IN_W-1) without overflow.
    assign w_zero    = (r_a == '0);
    assign w_in_sign = (SIGNED != 0) ? r_a[IN_W-1] : 1'b0;
    assign w_abs     = w_in_sign ? ((~r_a) + IN_W'(1)) : r_a;

`ifdef FIXED_TO_FLOAT_LZC_EN
    localparam int unsigned LZ_W = $clog2(IN_W + 1);
    logic [LZ_W-1:0] w_lz;

    fixed_to_float_lzc #(
        .WIDTH (IN_W)
    ) u_lzc (
        .i_vec (r_mag),
        .o_cnt (w_lz)
    );

    assign w_norm      = r_mag << w_lz;
    assign w_norm_exp  = r_exp - $signed(10'(w_lz));
    assign w_norm_done = 1'b1;
`else
    assign w_norm      = r_mag;
    assign w_norm_exp  = r_exp;
    assign w_norm_done = r_mag[IN_W-1];
`endif

    // Mantissa and rounding bits from the normalised magnitude; absent low bits read as 0.
    assign w_ext        = {w_norm, {PAD_W{1'b0}}};
    assign w_mant_ext   = w_ext[EXT_W-1 -: MANT_W+1];
    assign w_guard_ext  = w_ext[IN_W+1];
    assign w_round_ext  = w_ext[IN_W];
    assign w_sticky_ext = |w_ext[IN_W-1:0];

    assign w_inc = r_guard && (r_round || r_sticky || r_mant[0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            StIdle:      if (input_a_stb && r_ack) w_state_n = StConvert;
            StConvert:   w_state_n = w_zero ? StPack : StNormalise;
            StNormalise: if (w_norm_done) w_state_n = StRound;
            StRound:     w_state_n = StPack;
            StPack:      w_state_n = StPutZ;
            StPutZ:      if (r_stb && output_z_ack) w_state_n = StIdle;
            default:     w_state_n = StIdle;
        endcase
    end

    // Datapath and handshake next values per state.
    always_comb begin
        w_a_n      = r_a;
        w_sign_n   = r_sign;
        w_mag_n    = r_mag;
        w_exp_n    = r_exp;
        w_mant_n   = r_mant;
        w_guard_n  = r_guard;
        w_round_n  = r_round;
        w_sticky_n = r_sticky;
        w_z_n      = r_z;
        w_ack_n    = r_ack;
        w_stb_n    = r_stb;
        unique case (r_state)
            StIdle: begin
                w_ack_n = 1'b1;
                if (input_a_stb && r_ack) begin
                    w_a_n   = input_a;
                    w_ack_n = 1'b0;
                end
            end
            StConvert: begin
                if (w_zero) begin
                    w_sign_n = 1'b0;
                    w_mant_n = '0;
                    w_exp_n  = EXP_ZERO;
                end else begin
                    w_sign_n = w_in_sign;
                    w_mag_n  = w_abs;
                    w_exp_n  = EXP_INIT;
                end
            end
            StNormalise: begin
                if (w_norm_done) begin
                    w_mant_n   = w_mant_ext;
                    w_guard_n  = w_guard_ext;
                    w_round_n  = w_round_ext;
                    w_sticky_n = w_sticky_ext;
                    w_exp_n    = w_norm_exp;
                end else begin
                    w_mag_n = r_mag << 1;
                    w_exp_n = r_exp - 10'sd1;
                end
            end
            StRound: begin
                if (w_inc) begin
                    // Carry out of the mantissa renormalises to 1.0 x 2^(exp+1).
                    if (&r_mant) begin
                        w_mant_n = '0;
                        w_exp_n  = r_exp + 10'sd1;
                    end else begin
                        w_mant_n = r_mant + (MANT_W+1)'(1);
                    end
                end
            end
            StPack: begin
                w_z_n.sign = r_sign;
                w_z_n.exp  = EXP_W'(r_exp + EXP_BIAS_S);
                w_z_n.mant = r_mant[MANT_W-1:0];
                w_stb_n    = 1'b1;
            end
            StPutZ: begin
                if (output_z_ack) w_stb_n = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and handshake registers; reset discards any pending operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_guard  <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
            r_z      <= '0;
            r_ack    <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_a      <= w_a_n;
            r_sign   <= w_sign_n;
            r_mag    <= w_mag_n;
            r_exp    <= w_exp_n;
            r_mant   <= w_mant_n;
            r_guard  <= w_guard_n;
            r_round  <= w_round_n;
            r_sticky <= w_sticky_n;
            r_z      <= w_z_n;
            r_ack    <= w_ack_n;
            r_stb    <= w_stb_n;
        end
    end

    assign input_a_ack  = r_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_stb;

endmodule

// File: doc/fixed_to_float.md
# fixed_to_float

Parametrised fixed-point to IEEE-754 single-precision converter with strobe/ack handshakes on both sides. It generalises the 32-bit integer converter with configurable input width, fractional-bit count, signed or unsigned input, and round-to-nearest-even. It sits between fixed-point arithmetic stages, such as square-root and interpolation, and the float pipeline of the renderer.

## Interface
- IN_W, default 32: input width in bits; legal range 8..64.
- FRAC_W, default 16: number of fractional bits in input_a; legal range 0..IN_W-1.
- SIGNED, default 1: 1 means input_a is two's complement; 0 means input_a is unsigned.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- input_a  in  IN_W  fixed-point operand.
- input_a_stb  in  1  producer strobe; operand valid.
- input_a_ack  out  1  converter ready; a transfer occurs on an edge where stb && ack.
- output_z  out  32  IEEE single-precision result.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accept; a transfer occurs on an edge where stb && ack.

## Operation
- States: IDLE, CONVERT, NORMALISE, ROUND, PACK, PUT_Z.
- IDLE
  - Sets input_a_ack=1.
  - On stb&&ack: latches the operand, drops ack, goes to CONVERT.
- CONVERT
  - Operand == 0 → sign=0, mantissa=0, exponent=-127, go to PACK. Result is +0.0 (0x00000000).
  - SIGNED=1: sign=input MSB, magnitude = |operand| as IN_W-bit unsigned. The most negative value (-2^(IN_W-1)) therefore has magnitude 2^(IN_W-1), with no overflow.
  - SIGNED=0: sign=0, magnitude=operand.
  - Sets exponent = IN_W-1-FRAC_W, then goes to NORMALISE.
- NORMALISE
  - While magnitude MSB is 0: shift left 1 bit and decrement exponent, one bit per cycle.
  - When MSB is 1: mantissa = top 24 bits (low bits zero-filled if IN_W<24).
  - Rounding bits are taken below the mantissa: guard = next bit, round = the following bit, sticky = OR of all remaining bits (absent bits read as 0).
  - Then go to ROUND.
- ROUND: round-to-nearest-even.
  - Increment mantissa if guard && (round || sticky || mantissa[0]).
  - If the mantissa was 0xFFFFFF: mantissa becomes 0 and exponent increments.
- PACK: z = {sign, exponent+127 (8 bits), mantissa[22:0]}.
- PUT_Z
  - Drives output_z=z and output_z_stb=1.
  - On stb&&ack: drops stb, returns to IDLE.
- Result exponent always lies in the normal range for legal parameters; no denormal, infinity or NaN is ever produced.

## Timing
- Reset values: input_a_ack=0, output_z_stb=0, output_z=0, state=IDLE.
- input_a_ack rises one cycle after reset release or after entering IDLE.
- Reset mid-conversion: the pending operand is discarded; no output strobe is produced.
- Latency is counted from the accept edge to the first edge with output_z_stb=1:
  - Nonzero operand, iterative normalise: lz+5 edges, where lz is the number of leading zeros of the magnitude within IN_W bits.
  - Zero operand: 3 edges.
- output_z is stable while output_z_stb=1. Backpressure of any length is held without loss.
- input_a_ack stays 0 from the accept edge until the cycle after the output transfer; throughput is one conversion in flight.

## Configuration
- FIXED_TO_FLOAT_LZC_EN
  - Defined: NORMALISE completes in one cycle, using a combinational leading-zero count and a barrel shift. Latency for a nonzero operand is a fixed 5 edges.
  - Undefined: iterative one-bit-per-cycle normalise as above.
- Results are bit-identical in both builds.

## Structure
- Package fixed_to_float_pkg holds:
  - State enum typedef.
  - Float field constants: EXP_BIAS=127, MANT_W=23, EXP_W=8.
  - Packed struct float32_t {sign, exp, mant}.
- Sub-module fixed_to_float_lzc: parametrised leading-zero counter (width IN_W, output $clog2(IN_W+1) bits). It is instantiated only under FIXED_TO_FLOAT_LZC_EN.

## Test plan
All scenarios use IN_W=32, FRAC_W=16, SIGNED=1, and both macro settings.
- Input 0x00010000 (1.0) → output 0x3F800000. Latency is 20 edges iterative, 5 with LZC.
- Input 0xFFFF8000 (-0.5) → output 0xBF000000.
- Input 0x00000000 → output 0x00000000, with output_z_stb 3 edges after accept.
- Input 0x80000000 (-32768.0) → output 0xC7000000.
- Input 0x7FFFFFFF → round carry out of the mantissa → output 0x47000000.
- Input 0x01000001 (tie, even LSB) → output 0x43800000.
  - Hold output_z_ack=0 for 10 cycles: output_z stays stable and input_a_ack stays 0.
  - Assert rst mid-NORMALISE on the next operand: no stb, ack returns after 1 cycle.
